// File: rtl/imp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imp_pkg
// Description : Shared types for the image-read tile scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package imp_pkg;

    localparam int IMP_BEAT_W = 17;

    typedef struct packed {
        logic [7:0]  hsize;
        logic [7:0]  minx;
        logic [7:0]  vsize;
        logic [7:0]  miny;
        logic [31:0] baddr;
        logic [31:0] pitch;
    } imp_desc_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_ARM   = 3'd3,
        ST_RUN   = 3'd4,
        ST_DONE  = 3'd5,
        ST_DRAIN = 3'd6
    } imp_sched_st_e;

    // The engine walks x from 0, so each row costs minx+hsize beats.
    function automatic logic [IMP_BEAT_W-1:0] imp_beats(input imp_desc_t d);
        logic [IMP_BEAT_W-1:0] w_x;
        logic [IMP_BEAT_W-1:0] w_y;
        w_x = {{(IMP_BEAT_W-8){1'b0}}, d.minx} + {{(IMP_BEAT_W-8){1'b0}}, d.hsize};
        w_y = {{(IMP_BEAT_W-8){1'b0}}, d.vsize};
        return w_x * w_y;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imp_tile_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : imp_tile_sched_if
// Description : Descriptor push, engine config and engine handshake taps.
// Revision    : 1.0 - initial release
// ============================================================================
interface imp_tile_sched_if #(
    parameter int QDEPTH = 4
);
    import imp_pkg::*;

    logic                      desc_valid;
    logic                      desc_ready;
    logic [7:0]                desc_hsize;
    logic [7:0]                desc_minx;
    logic [7:0]                desc_vsize;
    logic [7:0]                desc_miny;
    logic [31:0]               desc_baddr;
    logic [31:0]               desc_pitch;
    logic                      abort;
    logic                      err_clr;
    logic                      mon_arvalid;
    logic                      mon_arready;
    logic                      mon_rvalid;
    logic                      mon_rready;
    logic [7:0]                IMP_HSIZE;
    logic [7:0]                IMP_COOR_MINX;
    logic [7:0]                IMP_VSIZE;
    logic [7:0]                IMP_COOR_MINY;
    logic [31:0]               IMP_SRC_BADDR;
    logic [31:0]               IMP_ADR_PITCH;
    logic                      IMP_ST;
    logic                      busy;
    logic                      job_done;
    logic                      job_abort;
    logic                      err_timeout;
    logic                      err_desc;
    logic [$clog2(QDEPTH):0]   q_level;

    modport slave (
        input  desc_valid, desc_hsize, desc_minx, desc_vsize, desc_miny,
               desc_baddr, desc_pitch, abort, err_clr,
               mon_arvalid, mon_arready, mon_rvalid, mon_rready,
        output desc_ready, IMP_HSIZE, IMP_COOR_MINX, IMP_VSIZE, IMP_COOR_MINY,
               IMP_SRC_BADDR, IMP_ADR_PITCH, IMP_ST, busy, job_done, job_abort,
               err_timeout, err_desc, q_level
    );

    modport master (
        output desc_valid, desc_hsize, desc_minx, desc_vsize, desc_miny,
               desc_baddr, desc_pitch, abort, err_clr,
               mon_arvalid, mon_arready, mon_rvalid, mon_rready,
        input  desc_ready, IMP_HSIZE, IMP_COOR_MINX, IMP_VSIZE, IMP_COOR_MINY,
               IMP_SRC_BADDR, IMP_ADR_PITCH, IMP_ST, busy, job_done, job_abort,
               err_timeout, err_desc, q_level
    );

endinterface
`default_nettype wire

// File: rtl/imp_desc_fifo.sv
`default_nettype none
// ============================================================================
// Module      : imp_desc_fifo
// Description : Synchronous descriptor FIFO with flush and occupancy output.
// Revision    : 1.0 - initial release
// ============================================================================
module imp_desc_fifo
    import imp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire                     clk,
    input  wire                     rst_n,
    input  wire                     i_flush,
    input  wire                     i_push,
    input  wire imp_desc_t          i_data,
    input  wire                     i_pop,
    output imp_desc_t               o_data,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_level
);

    localparam int                c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]     c_FULL = (c_AW + 1)'(DEPTH);

    imp_desc_t        r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_level == c_FULL);
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/imp_tile_sched.sv
`default_nettype none
// ============================================================================
// Module      : imp_tile_sched
// Description : Queues tile descriptors and launches the image read engine.
// Revision    : 1.0 - initial release
// ============================================================================
module imp_tile_sched
    import imp_pkg::*;
#(
    parameter int QDEPTH = 4,
    parameter int TO_W   = 16
) (
    input  wire              clk,
    input  wire              rst_n,
    imp_tile_sched_if.slave  bus
);

    localparam int              c_LW      = $clog2(QDEPTH) + 1;
    localparam logic [TO_W-1:0] c_TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    imp_sched_st_e          r_state;
    imp_desc_t              r_cfg;
    logic [IMP_BEAT_W-1:0]  r_beats_exp;
    logic [IMP_BEAT_W-1:0]  r_ar_cnt;
    logic [IMP_BEAT_W-1:0]  r_r_cnt;
    logic [TO_W-1:0]        r_to_cnt;
    logic                   r_imp_st;
    logic                   r_job_done;
    logic                   r_job_abort;
    logic                   r_err_timeout;
    logic                   r_err_desc;

    imp_desc_t              w_push_desc;
    imp_desc_t              w_head;
    logic                   w_full;
    logic                   w_empty;
    logic [c_LW-1:0]        w_level;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_flush;
    logic                   w_head_zero;
    logic                   w_ar_hs;
    logic                   w_r_hs;
    logic                   w_counting;
    logic                   w_to_expire;
    logic                   w_complete;
    logic [IMP_BEAT_W-1:0]  w_ar_nxt;
    logic [IMP_BEAT_W-1:0]  w_r_nxt;

    assign w_push_desc = '{hsize: bus.desc_hsize, minx: bus.desc_minx,
                           vsize: bus.desc_vsize, miny: bus.desc_miny,
                           baddr: bus.desc_baddr, pitch: bus.desc_pitch};

    assign w_push      = bus.desc_valid & ~w_full & ~bus.abort;
    assign w_pop       = (r_state == ST_LOAD);
    assign w_flush     = bus.abort | w_to_expire;
    assign w_head_zero = (w_head.hsize == 8'd0) || (w_head.vsize == 8'd0);

    imp_desc_fifo #(
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_data  (w_push_desc),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    assign w_ar_hs    = bus.mon_arvalid & bus.mon_arready;
    assign w_r_hs     = bus.mon_rvalid & bus.mon_rready;
    // DRAIN is timed too so an aborted job whose engine stalls cannot hang the block.
    assign w_counting = (r_state == ST_ARM) || (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_ar_nxt   = (w_ar_hs && (r_ar_cnt != '1)) ? r_ar_cnt + 1'b1 : r_ar_cnt;
    assign w_r_nxt    = (w_r_hs && (r_r_cnt < w_ar_nxt)) ? r_r_cnt + 1'b1 : r_r_cnt;
    assign w_complete = (r_ar_cnt == r_beats_exp) && (r_r_cnt == r_ar_cnt);
    assign w_to_expire = w_counting && !w_r_hs && (r_to_cnt == c_TO_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cfg         <= '0;
            r_beats_exp   <= '0;
            r_ar_cnt      <= '0;
            r_r_cnt       <= '0;
            r_to_cnt      <= '0;
            r_imp_st      <= 1'b0;
            r_job_done    <= 1'b0;
            r_job_abort   <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_desc    <= 1'b0;
        end else begin
            r_imp_st    <= 1'b0;
            r_job_done  <= 1'b0;
            r_job_abort <= 1'b0;

            if (w_counting) begin
                r_ar_cnt <= w_ar_nxt;
                r_r_cnt  <= w_r_nxt;
                r_to_cnt <= w_r_hs ? '0 : r_to_cnt + 1'b1;
            end

            if (w_to_expire)      r_err_timeout <= 1'b1;
            else if (bus.err_clr) r_err_timeout <= 1'b0;

            if ((r_state == ST_LOAD) && w_head_zero) r_err_desc <= 1'b1;
            else if (bus.err_clr)                    r_err_desc <= 1'b0;

            if (w_to_expire) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (!w_empty && !r_err_timeout && !bus.abort) r_state <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        if (bus.abort || w_head_zero) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_cfg       <= w_head;
                            r_beats_exp <= imp_beats(w_head);
                            r_imp_st    <= 1'b1;
                            r_state     <= ST_START;
                        end
                    end
                    ST_START: begin
                        r_ar_cnt <= '0;
                        r_r_cnt  <= '0;
                        r_to_cnt <= '0;
                        r_state  <= bus.abort ? ST_DRAIN : ST_ARM;
                    end
                    ST_ARM: begin
                        if (bus.abort)            r_state <= ST_DRAIN;
                        else if (bus.mon_arvalid) r_state <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (bus.abort) begin
                            r_state <= ST_DRAIN;
                        end else if (w_complete) begin
                            r_job_done <= 1'b1;
                            r_state    <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                    end
                    ST_DRAIN: begin
                        if (w_complete) begin
                            r_job_abort <= 1'b1;
                            r_state     <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.desc_ready    = ~w_full;
    assign bus.IMP_HSIZE     = r_cfg.hsize;
    assign bus.IMP_COOR_MINX = r_cfg.minx;
    assign bus.IMP_VSIZE     = r_cfg.vsize;
    assign bus.IMP_COOR_MINY = r_cfg.miny;
    assign bus.IMP_SRC_BADDR = r_cfg.baddr;
    assign bus.IMP_ADR_PITCH = r_cfg.pitch;
    assign bus.IMP_ST        = r_imp_st;
    assign bus.busy          = (r_state != ST_IDLE) || !w_empty;
    assign bus.job_done      = r_job_done;
    assign bus.job_abort     = r_job_abort;
    assign bus.err_timeout   = r_err_timeout;
    assign bus.err_desc      = r_err_desc;
    assign bus.q_level       = w_level;

endmodule
`default_nettype wire

// File: tb/tb_imp_tile_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_imp_tile_sched
// Description : Directed bench with a simple engine model for imp_tile_sched.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imp_tile_sched;
    import imp_pkg::*;

    typedef struct { imp_desc_t d; int beats; bit no_r; } exp_t;
    typedef struct { imp_desc_t d; int beats; bit bad; } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   st_cnt = 0, done_cnt = 0, abort_cnt = 0, eng_r_sent = 0;
    bit   eng_busy = 1'b0;
    exp_t exp_q[$];

    imp_tile_sched_if #(.QDEPTH(4)) bus();

    imp_tile_sched #(.QDEPTH(4), .TO_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic imp_desc_t mk(input logic [7:0] h, input logic [7:0] mx,
                                     input logic [7:0] v, input logic [7:0] my,
                                     input logic [31:0] b, input logic [31:0] p);
        imp_desc_t d;
        d.hsize = h; d.minx = mx; d.vsize = v; d.miny = my; d.baddr = b; d.pitch = p;
        return d;
    endfunction

    task automatic set_desc(input imp_desc_t d);
        bus.desc_valid = 1'b1;
        bus.desc_hsize = d.hsize;
        bus.desc_minx  = d.minx;
        bus.desc_vsize = d.vsize;
        bus.desc_miny  = d.miny;
        bus.desc_baddr = d.baddr;
        bus.desc_pitch = d.pitch;
    endtask

    task automatic push_desc(input imp_desc_t d);
        set_desc(d);
        @(negedge clk);
        bus.desc_valid = 1'b0;
    endtask

    // which: 0 job_done, 1 job_abort, 2 IMP_ST, 3 err_timeout
    task automatic wait_for(input int which, input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((which == 0 && bus.job_done)  || (which == 1 && bus.job_abort) ||
                (which == 2 && bus.IMP_ST)    || (which == 3 && bus.err_timeout)) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic chk_cfg(input string name, input imp_desc_t d);
        chk({name, "_geom"},
            {32'd0, bus.IMP_HSIZE, bus.IMP_COOR_MINX, bus.IMP_VSIZE, bus.IMP_COOR_MINY},
            {32'd0, d.hsize, d.minx, d.vsize, d.miny});
        chk({name, "_addr"}, {bus.IMP_SRC_BADDR, bus.IMP_ADR_PITCH}, {d.baddr, d.pitch});
    endtask

    // Engine model: first AR two cycles after IMP_ST, one AR per cycle, R lagging by one.
    initial begin : engine
        exp_t e;
        bit   has;
        bus.mon_arvalid = 1'b0; bus.mon_arready = 1'b0;
        bus.mon_rvalid  = 1'b0; bus.mon_rready  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.IMP_ST === 1'b1) begin
                st_cnt++;
                has = (exp_q.size() != 0);
                chk("st_expected", {63'd0, has}, 64'd1);
                if (has) begin
                    e = exp_q.pop_front();
                    chk_cfg("cfg_launch", e.d);
                    eng_busy   = 1'b1;
                    eng_r_sent = 0;
                    @(negedge clk);
                    @(negedge clk);
                    for (int i = 0; i <= e.beats; i++) begin
                        bus.mon_arvalid = (i < e.beats);
                        bus.mon_arready = (i < e.beats);
                        bus.mon_rvalid  = (i >= 1) && !e.no_r;
                        bus.mon_rready  = (i >= 1) && !e.no_r;
                        if (bus.mon_rvalid) eng_r_sent++;
                        @(negedge clk);
                    end
                    bus.mon_arvalid = 1'b0; bus.mon_arready = 1'b0;
                    bus.mon_rvalid  = 1'b0; bus.mon_rready  = 1'b0;
                    chk_cfg("cfg_hold", e.d);
                    eng_busy = 1'b0;
                end
            end
        end
    end

    initial begin : monitor
        bit p_st, p_done, p_ab;
        p_st = 1'b0; p_done = 1'b0; p_ab = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (p_st)   chk("st_1T",    {63'd0, bus.IMP_ST},    64'd0);
                if (p_done) chk("done_1T",  {63'd0, bus.job_done},  64'd0);
                if (p_ab)   chk("abort_1T", {63'd0, bus.job_abort}, 64'd0);
                if (bus.job_done) begin
                    done_cnt++;
                    chk("done_after_last_r", {63'd0, eng_busy}, 64'd0);
                end
                if (bus.job_abort) begin
                    abort_cnt++;
                    chk("abort_after_last_r", {63'd0, eng_busy}, 64'd0);
                end
            end
            p_st = bus.IMP_ST; p_done = bus.job_done; p_ab = bus.job_abort;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t      vecs [7];
        imp_desc_t b2b  [4];
        int        b2b_beats [4];
        bit        got;
        int        st0, d0, a0;

        bus.desc_valid = 1'b0; bus.abort = 1'b0; bus.err_clr = 1'b0;
        set_desc(mk(0, 0, 0, 0, 0, 0));
        bus.desc_valid = 1'b0;

        vecs[0] = '{mk(4, 0, 2, 0, 32'h1000, 32'h40),   8, 1'b0};
        vecs[1] = '{mk(3, 2, 2, 5, 32'h2000, 32'h80),  10, 1'b0};
        vecs[2] = '{mk(1, 0, 1, 1, 32'h2400, 32'h10),   1, 1'b0};
        vecs[3] = '{mk(4, 0, 0, 0, 32'h2800, 32'h40),   0, 1'b1};
        vecs[4] = '{mk(5, 3, 3, 2, 32'h3000, 32'h20),  24, 1'b0};
        vecs[5] = '{mk(0, 1, 3, 0, 32'h3400, 32'h20),   0, 1'b1};
        vecs[6] = '{mk(2, 7, 1, 9, 32'h3800, 32'h100),  9, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_st",      {63'd0, bus.IMP_ST},      64'd0);
        chk("rst_busy",    {63'd0, bus.busy},        64'd0);
        chk("rst_level",   {61'd0, bus.q_level},     64'd0);
        chk("rst_done",    {62'd0, bus.job_done, bus.job_abort}, 64'd0);
        chk("rst_err",     {62'd0, bus.err_timeout, bus.err_desc}, 64'd0);
        chk_cfg("rst_cfg", mk(0, 0, 0, 0, 0, 0));
        chk("rst_ready",   {63'd0, bus.desc_ready},  64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            st0 = st_cnt;
            if (!vecs[i].bad) exp_q.push_back('{vecs[i].d, vecs[i].beats, 1'b0});
            push_desc(vecs[i].d);
            if (vecs[i].bad) begin
                repeat (6) @(negedge clk);
                chk($sformatf("vec%0d_err_desc", i), {63'd0, bus.err_desc}, 64'd1);
                chk($sformatf("vec%0d_no_st", i), 64'(st_cnt - st0), 64'd0);
                chk($sformatf("vec%0d_busy", i), {63'd0, bus.busy}, 64'd0);
                bus.err_clr = 1'b1;
                @(negedge clk);
                bus.err_clr = 1'b0;
                chk($sformatf("vec%0d_err_clr", i), {63'd0, bus.err_desc}, 64'd0);
            end else begin
                wait_for(0, 300, got);
                chk($sformatf("vec%0d_done", i), {63'd0, got}, 64'd1);
                chk($sformatf("vec%0d_r_beats", i), 64'(eng_r_sent), 64'(vecs[i].beats));
                @(negedge clk);
                chk($sformatf("vec%0d_idle", i), {62'd0, bus.busy, bus.err_desc}, 64'd0);
            end
        end

        // Fill the queue while a long job runs; the fifth push must be refused.
        b2b[0] = mk(2, 0, 2, 1, 32'h5000, 32'h20); b2b_beats[0] = 4;
        b2b[1] = mk(3, 1, 1, 2, 32'h5100, 32'h30); b2b_beats[1] = 4;
        b2b[2] = mk(1, 1, 3, 3, 32'h5200, 32'h40); b2b_beats[2] = 6;
        b2b[3] = mk(4, 0, 1, 4, 32'h5300, 32'h50); b2b_beats[3] = 4;
        d0 = done_cnt;
        exp_q.push_back('{mk(8, 0, 4, 1, 32'h8000, 32'h100), 32, 1'b0});
        push_desc(mk(8, 0, 4, 1, 32'h8000, 32'h100));
        wait_for(2, 20, got);
        chk("b2b_launch", {63'd0, got}, 64'd1);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back('{b2b[k], b2b_beats[k], 1'b0});
            set_desc(b2b[k]);
            @(negedge clk);
        end
        chk("b2b_level_full", {61'd0, bus.q_level}, 64'd4);
        chk("b2b_ready_low", {63'd0, bus.desc_ready}, 64'd0);
        set_desc(mk(9, 9, 9, 9, 32'hDEAD0000, 32'h999));
        @(negedge clk);
        bus.desc_valid = 1'b0;
        chk("b2b_fifth_dropped", {61'd0, bus.q_level}, 64'd4);
        for (int k = 0; k < 5; k++) begin
            wait_for(0, 300, got);
            chk($sformatf("b2b_done%0d", k), {63'd0, got}, 64'd1);
        end
        @(negedge clk);
        chk("b2b_done_cnt", 64'(done_cnt - d0), 64'd5);
        chk("b2b_exp_empty", 64'(exp_q.size()), 64'd0);
        chk("b2b_busy", {63'd0, bus.busy}, 64'd0);

        // Abort mid-RUN with two queued; a push in the abort cycle is discarded.
        exp_q.push_back('{mk(8, 0, 2, 0, 32'h9000, 32'h40), 16, 1'b0});
        push_desc(mk(8, 0, 2, 0, 32'h9000, 32'h40));
        wait_for(2, 20, got);
        chk("abort_launch", {63'd0, got}, 64'd1);
        set_desc(mk(2, 0, 2, 0, 32'h9100, 32'h40));
        @(negedge clk);
        set_desc(mk(3, 0, 2, 0, 32'h9200, 32'h40));
        @(negedge clk);
        bus.desc_valid = 1'b0;
        chk("abort_pre_level", {61'd0, bus.q_level}, 64'd2);
        repeat (4) @(negedge clk);
        d0 = done_cnt; a0 = abort_cnt; st0 = st_cnt;
        bus.abort = 1'b1;
        set_desc(mk(1, 0, 1, 0, 32'h9300, 32'h40));
        @(negedge clk);
        bus.abort = 1'b0;
        bus.desc_valid = 1'b0;
        chk("abort_flush", {61'd0, bus.q_level}, 64'd0);
        wait_for(1, 100, got);
        chk("abort_pulse", {63'd0, got}, 64'd1);
        chk("abort_r_beats", 64'(eng_r_sent), 64'd16);
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
        repeat (10) @(negedge clk);
        chk("abort_no_relaunch", 64'(st_cnt - st0), 64'd0);
        chk("abort_cnt", 64'(abort_cnt - a0), 64'd1);
        chk("abort_busy", {63'd0, bus.busy}, 64'd0);

        // R channel silent: timeout after 15 timed cycles following IMP_ST.
        exp_q.push_back('{mk(4, 0, 2, 0, 32'hA000, 32'h40), 8, 1'b1});
        push_desc(mk(4, 0, 2, 0, 32'hA000, 32'h40));
        wait_for(2, 20, got);
        chk("to_launch", {63'd0, got}, 64'd1);
        repeat (14) @(negedge clk);
        chk("to_early", {63'd0, bus.err_timeout}, 64'd0);
        @(negedge clk);
        chk("to_edge_before", {63'd0, bus.err_timeout}, 64'd0);
        @(negedge clk);
        chk("to_set", {63'd0, bus.err_timeout}, 64'd1);
        chk("to_idle", {63'd0, bus.busy}, 64'd0);

        exp_q.push_back('{mk(2, 1, 2, 0, 32'hB000, 32'h40), 6, 1'b0});
        st0 = st_cnt;
        push_desc(mk(2, 1, 2, 0, 32'hB000, 32'h40));
        repeat (8) @(negedge clk);
        chk("to_blocked_st", 64'(st_cnt - st0), 64'd0);
        chk("to_blocked_busy", {63'd0, bus.busy}, 64'd1);
        chk("to_blocked_level", {61'd0, bus.q_level}, 64'd1);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        chk("to_cleared", {63'd0, bus.err_timeout}, 64'd0);
        wait_for(0, 100, got);
        chk("to_resume_done", {63'd0, got}, 64'd1);
        @(negedge clk);
        chk("to_resume_busy", {63'd0, bus.busy}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
